matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Control and storage block for the TPU's 2×2 signed 8-bit matrix multiply: it captures operand bytes streamed over the 8-bit input bus into A/B buffers. Once all eight operands are present, it sequences a single shared multiply-accumulate unit through the eight products of C = A·B. It then holds the four 16-bit results for byte-wise readout and raises `done`. It sits directly under the tt_um_tpu top, which maps `ui_in`, `uio_in` and `uo_out` onto its ports.

## Interface
- `DATA_W`, 8: operand width, signed two's complement.
- `ACC_W`, 16: result width, signed two's complement.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset (top drives `~rst_n`).
- `load_en` input 1: write `in_data` into the operand buffer this cycle.
- `load_sel_ab` input 1: 0 = matrix A, 1 = matrix B.
- `load_index` input 2: element index {row, col}.
- `in_data` input 8: operand byte.
- `output_en` input 1: request a result byte.
- `output_sel` input 2: result element index {row, col}.
- `output_hi` input 1: 0 = result bits [7:0], 1 = bits [15:8].
- `out_data` output 8: registered result byte.
- `done` output 1: results valid, held until the next load.

## Operation
- States: LOAD, COMPUTE, DONE. Reset state is LOAD.
- Reset clears:
  - all A, B and C registers, the 8-bit valid mask and the step counter;
  - `out_data` to 0 and `done` to 0.
- LOAD:
  - `load_en` writes A[idx] or B[idx] and sets that valid bit.
  - Rewriting an index overwrites the value; the mask bit stays set.
  - When a write completes the mask (all 8 bits), the next state is COMPUTE.
- COMPUTE:
  - A 3-bit step counter runs 0..7: i = step[2:1] (C element), k = step[0].
  - Element indices: row r = i[1], col c = i[0].
  - Product p = A[r][k]·B[k][c], sign-extended to 16 bits.
  - k=0: acc <= p.
  - k=1: C[i] <= acc + p.
  - After step 7 the next state is DONE.
  - `load_en` is ignored in COMPUTE.
- DONE:
  - `done` = 1.
  - A `load_en` does all of the following, all on that edge:
    - clears the mask;
    - writes the addressed entry and sets its valid bit;
    - clears `done`;
    - moves to LOAD.
  - A, B and C are retained until overwritten.
- Arithmetic: 16-bit sums wrap modulo 2^16; there is no saturation and no overflow flag.
- Readout: each edge, if `output_en` and state is DONE, `out_data` <= selected byte of C[output_sel]; otherwise `out_data` <= 0.

## Timing
- Load: the operand is visible in its buffer one edge after capture.
- Compute latency: call the edge capturing the final operand E0.
  - COMPUTE occupies E1..E8; `done` = 1 after E8.
  - A final load to done therefore takes 8 cycles.
  - Throughput: one product per cycle.
- Readout latency: 1 cycle from `output_en` to valid `out_data`.
- Simultaneous load in DONE and `output_en`: the load wins and `out_data` <= 0.
- `rst` asserted mid-COMPUTE: next state is LOAD with everything cleared, and no partial C is retained.

## Structure
- Shared package `tpu_pkg`:
  - state enum {LOAD, COMPUTE, DONE};
  - `DATA_W` and `ACC_W` constants;
  - the index field layout (row = bit 1, col = bit 0).
- Sub-module `mac_unit`: combinational, signed 8×8 multiply plus 16-bit add with a `first` input selecting p vs acc+p.
  - The sequencer owns the accumulator register.
  - `mac_unit` is sized for later reuse by a systolic variant.

## Test plan
- Basic multiply: load A = [1,2;3,4], B = [5,6;7,8].
  - `done` rises 8 cycles after the last load.
  - Reads return C = [19,22;43,50]; all high bytes are 0x00.
- Signed operands: A = [-1,2;3,-4], B = [5,-6;7,8].
  - C = [9,22;-13,-50].
  - C[3] low byte = 0xCE, high byte = 0xFF.
- Wrap-around: all operands -128.
  - Every C = 0x8000: low byte 0x00, high byte 0x80.
- Overwrite and ordering:
  - Load the B elements in reverse order, then rewrite A[0] = 9 before completion, then load the rest of A = [_,2;3,4] with B = [5,6;7,8].
  - C[0] = 59 (9·5 + 2·7).
  - COMPUTE starts only after all 8 indices are written.
- Reset mid-compute:
  - Assert `rst` 3 cycles into COMPUTE.
  - `done` stays 0 and `out_data` = 0.
  - A fresh full load then gives correct results.
- DONE behaviour:
  - `output_en` in LOAD gives `out_data` = 0.
  - `load_en` during COMPUTE is ignored, and the results match the pre-compute operands.
  - A load in DONE drops `done` on the next cycle.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU matrix-multiply datapath.
// Element indices pack {row, col} into two bits.
package tpu_pkg;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 16;
  localparam int IDX_ROW = 1;
  localparam int IDX_COL = 0;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic logic [1:0] elem_idx(input logic row, input logic col);
    logic [1:0] idx;
    idx          = '0;
    idx[IDX_ROW] = row;
    idx[IDX_COL] = col;
    return idx;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational signed multiply-accumulate: result = p or acc + p, where p = a*b.
// Sums wrap modulo 2^ACC_W.
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic                     first,
  output logic signed [ACC_W-1:0]  result
);

  function automatic logic signed [ACC_W-1:0] wrap_add(
    input logic signed [ACC_W-1:0] x,
    input logic signed [ACC_W-1:0] y
  );
    return x + y;
  endfunction

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);
  assign result   = first ? prod_ext : wrap_add(acc, prod_ext);

endmodule

// File: rtl/matmul_sequencer.sv
// 2x2 signed matrix multiply sequencer: buffers A/B operands, steps one shared
// MAC through the eight products of C = A*B, then serves result bytes.
module matmul_sequencer
  import tpu_pkg::*;
#(
  parameter int DATA_W = tpu_pkg::DATA_W,
  parameter int ACC_W  = tpu_pkg::ACC_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic       load_sel_ab,
  input  logic [1:0] load_index,
  input  logic [7:0] in_data,
  input  logic       output_en,
  input  logic [1:0] output_sel,
  input  logic       output_hi,
  output logic [7:0] out_data,
  output logic       done
);

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] a_q [4];
  logic signed [DATA_W-1:0] b_q [4];
  logic signed [ACC_W-1:0]  c_q [4];
  logic signed [ACC_W-1:0]  acc_q;
  logic [2:0]               step_q;
  logic [7:0]               mask_q;
  logic [7:0]               wr_bit;
  logic [7:0]               mask_next;
  logic                     load_accept;
  logic                     computing;

  logic [1:0]               c_idx;
  logic                     k_sel;
  logic signed [ACC_W-1:0]  mac_result;
  logic [ACC_W-1:0]         rd_word;

  assign wr_bit      = 8'b1 << {load_sel_ab, load_index};
  assign load_accept = load_en && (state_q != ST_COMPUTE);
  // A load arriving in DONE starts a fresh operand set.
  assign mask_next   = (state_q == ST_DONE) ? wr_bit : (mask_q | wr_bit);

  assign c_idx = step_q[2:1];
  assign k_sel = step_q[0];

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a      (a_q[elem_idx(c_idx[1], k_sel)]),
    .b      (b_q[elem_idx(k_sel, c_idx[0])]),
    .acc    (acc_q),
    .first  (~k_sel),
    .result (mac_result)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:    if (load_en && ((mask_q | wr_bit) == 8'hFF)) state_d = ST_COMPUTE;
      ST_COMPUTE: if (step_q == 3'd7) state_d = ST_DONE;
      ST_DONE:    if (load_en) state_d = ST_LOAD;
      default:    state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    done      = (state_q == ST_DONE);
    computing = (state_q == ST_COMPUTE);
  end

  assign rd_word = c_q[output_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
      acc_q    <= '0;
      step_q   <= '0;
      mask_q   <= '0;
      out_data <= '0;
    end else begin
      if (load_accept) begin
        if (load_sel_ab) b_q[load_index] <= in_data;
        else             a_q[load_index] <= in_data;
        mask_q <= mask_next;
      end
      // Even steps seed the accumulator, odd steps retire a C element.
      if (computing) begin
        step_q <= step_q + 3'd1;
        if (!k_sel) acc_q        <= mac_result;
        else        c_q[c_idx]   <= mac_result;
      end
      if (output_en && done && !load_en)
        out_data <= output_hi ? rd_word[15:8] : rd_word[7:0];
      else
        out_data <= '0;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer against an integer matrix model.
`timescale 1ns/1ps
module tb_matmul_sequencer;

  logic       clk = 0;
  logic       rst;
  logic       load_en;
  logic       load_sel_ab;
  logic [1:0] load_index;
  logic [7:0] in_data;
  logic       output_en;
  logic [1:0] output_sel;
  logic       output_hi;
  logic [7:0] out_data;
  logic       done;

  int errors = 0;
  int checks = 0;

  int          ma [4];
  int          mb [4];
  logic [15:0] mc [4];

  matmul_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_sel_ab (load_sel_ab),
    .load_index  (load_index),
    .in_data     (in_data),
    .output_en   (output_en),
    .output_sel  (output_sel),
    .output_hi   (output_hi),
    .out_data    (out_data),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic compute_model();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        int s;
        s = ma[r*2] * mb[c] + ma[r*2+1] * mb[2+c];
        mc[r*2+c] = s[15:0];
      end
  endtask

  task automatic load_elem(input logic sel, input int idx, input int val);
    logic [31:0] v;
    logic [31:0] ix;
    v  = val;
    ix = idx;
    @(negedge clk);
    load_en     = 1;
    load_sel_ab = sel;
    load_index  = ix[1:0];
    in_data     = v[7:0];
    @(posedge clk);
    #1 load_en = 0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 4; i++) load_elem(1'b0, i, ma[i]);
    for (int i = 0; i < 4; i++) load_elem(1'b1, i, mb[i]);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic read_byte(input int sel, input logic hi, output logic [7:0] v);
    logic [31:0] s;
    s = sel;
    @(negedge clk);
    output_en  = 1;
    output_sel = s[1:0];
    output_hi  = hi;
    @(posedge clk);
    #1 output_en = 0;
    v = out_data;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    read_byte(0, 1'b0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_out got=%02h exp=00", v); end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_basic();
    int cyc;
    logic [7:0] v, e;
    ma = '{1, 2, 3, 4};
    mb = '{5, 6, 7, 8};
    compute_model();
    load_all();
    wait_done(cyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", cyc); end
    for (int i = 0; i < 4; i++)
      for (int h = 0; h < 2; h++) begin
        read_byte(i, h[0], v);
        e = h[0] ? mc[i][15:8] : mc[i][7:0];
        checks++;
        if (v !== e) begin errors++; $display("FAIL basic_c%0d_%s got=%02h exp=%02h", i, h ? "hi" : "lo", v, e); end
      end
  endtask

  task automatic test_signed();
    int cyc;
    logic [7:0] v, e;
    ma = '{-1, 2, 3, -4};
    mb = '{5, -6, 7, 8};
    compute_model();
    load_all();
    wait_done(cyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL signed_latency got=%0d exp=8", cyc); end
    for (int i = 0; i < 4; i++)
      for (int h = 0; h < 2; h++) begin
        read_byte(i, h[0], v);
        e = h[0] ? mc[i][15:8] : mc[i][7:0];
        checks++;
        if (v !== e) begin errors++; $display("FAIL signed_c%0d_%s got=%02h exp=%02h", i, h ? "hi" : "lo", v, e); end
      end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [7:0] v, e;
    ma = '{-128, -128, -128, -128};
    mb = '{-128, -128, -128, -128};
    compute_model();
    load_all();
    wait_done(cyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL wrap_latency got=%0d exp=8", cyc); end
    for (int i = 0; i < 4; i++)
      for (int h = 0; h < 2; h++) begin
        read_byte(i, h[0], v);
        e = h[0] ? mc[i][15:8] : mc[i][7:0];
        checks++;
        if (v !== e) begin errors++; $display("FAIL wrap_c%0d_%s got=%02h exp=%02h", i, h ? "hi" : "lo", v, e); end
      end
  endtask

  task automatic test_overwrite();
    int cyc;
    logic [7:0] v, e;
    ma = '{9, 2, 3, 4};
    mb = '{5, 6, 7, 8};
    compute_model();
    for (int i = 3; i >= 0; i--) load_elem(1'b1, i, mb[i]);
    load_elem(1'b0, 0, 1);
    load_elem(1'b0, 0, 9);
    load_elem(1'b0, 1, 2);
    load_elem(1'b0, 2, 3);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL ovw_early_done got=%0b exp=0", done); end
    load_elem(1'b0, 3, 4);
    wait_done(cyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL ovw_latency got=%0d exp=8", cyc); end
    for (int i = 0; i < 4; i++) begin
      read_byte(i, 1'b0, v);
      e = mc[i][7:0];
      checks++;
      if (v !== e) begin errors++; $display("FAIL ovw_c%0d_lo got=%02h exp=%02h", i, v, e); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [7:0] v, e;
    ma = '{11, -7, 25, 3};
    mb = '{-2, 14, 6, -9};
    load_all();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1 rst = 0;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%0b exp=0", done); end
    read_byte(0, 1'b0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rstmid_out got=%02h exp=00", v); end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rstmid_late_done got=%0b exp=0", done); end
    ma = '{-50, 33, 17, 100};
    mb = '{77, -90, 4, 127};
    compute_model();
    load_all();
    wait_done(cyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL rstmid_latency got=%0d exp=8", cyc); end
    for (int i = 0; i < 4; i++)
      for (int h = 0; h < 2; h++) begin
        read_byte(i, h[0], v);
        e = h[0] ? mc[i][15:8] : mc[i][7:0];
        checks++;
        if (v !== e) begin errors++; $display("FAIL rstmid_c%0d_%s got=%02h exp=%02h", i, h ? "hi" : "lo", v, e); end
      end
  endtask

  task automatic test_done_behaviour();
    int cyc;
    logic [7:0] v, e;
    ma = '{12, -34, 56, -78};
    mb = '{-9, 87, 65, -43};
    compute_model();
    load_elem(1'b0, 0, ma[0]);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_drop got=%0b exp=0", done); end
    read_byte(0, 1'b0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL load_state_out got=%02h exp=00", v); end
    for (int i = 1; i < 4; i++) load_elem(1'b0, i, ma[i]);
    for (int i = 0; i < 4; i++) load_elem(1'b1, i, mb[i]);
    load_elem(1'b0, 0, 100);
    load_elem(1'b1, 3, -1);
    wait_done(cyc);
    checks++;
    if (cyc + 2 !== 8) begin errors++; $display("FAIL busy_latency got=%0d exp=8", cyc + 2); end
    for (int i = 0; i < 4; i++)
      for (int h = 0; h < 2; h++) begin
        read_byte(i, h[0], v);
        e = h[0] ? mc[i][15:8] : mc[i][7:0];
        checks++;
        if (v !== e) begin errors++; $display("FAIL busy_c%0d_%s got=%02h exp=%02h", i, h ? "hi" : "lo", v, e); end
      end
    ma = '{3, 1, -4, 1};
    mb = '{5, -9, 2, 6};
    compute_model();
    @(negedge clk);
    load_en = 1; load_sel_ab = 0; load_index = 2'd0; in_data = 8'd3;
    output_en = 1; output_sel = 2'd0; output_hi = 0;
    @(posedge clk);
    #1 load_en = 0;
    output_en = 0;
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL load_wins_out got=%02h exp=00", out_data); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL load_wins_done got=%0b exp=0", done); end
    for (int i = 1; i < 4; i++) load_elem(1'b0, i, ma[i]);
    for (int i = 0; i < 4; i++) load_elem(1'b1, i, mb[i]);
    wait_done(cyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL reload_latency got=%0d exp=8", cyc); end
    for (int i = 0; i < 4; i++) begin
      read_byte(i, 1'b1, v);
      e = mc[i][15:8];
      checks++;
      if (v !== e) begin errors++; $display("FAIL reload_c%0d_hi got=%02h exp=%02h", i, v, e); end
    end
  endtask

  task automatic test_random();
    int cyc;
    int ord [8];
    logic [7:0] v, e;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 4; i++) begin
        ma[i] = int'($urandom_range(0, 255)) - 128;
        mb[i] = int'($urandom_range(0, 255)) - 128;
      end
      compute_model();
      for (int i = 0; i < 8; i++) ord[i] = i;
      for (int i = 7; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(0, i));
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int i = 0; i < 8; i++)
        if (ord[i] >= 4) load_elem(1'b1, ord[i] - 4, mb[ord[i] - 4]);
        else             load_elem(1'b0, ord[i], ma[ord[i]]);
      wait_done(cyc);
      checks++;
      if (cyc !== 8) begin errors++; $display("FAIL rand%0d_latency got=%0d exp=8", it, cyc); end
      for (int i = 0; i < 4; i++)
        for (int h = 0; h < 2; h++) begin
          read_byte(i, h[0], v);
          e = h[0] ? mc[i][15:8] : mc[i][7:0];
          checks++;
          if (v !== e) begin errors++; $display("FAIL rand%0d_c%0d_%s got=%02h exp=%02h", it, i, h ? "hi" : "lo", v, e); end
        end
    end
  endtask

  initial begin
    rst = 1; load_en = 0; load_sel_ab = 0; load_index = 0; in_data = 0;
    output_en = 0; output_sel = 0; output_hi = 0;
    test_reset();
    test_basic();
    test_signed();
    test_wrap();
    test_overwrite();
    test_reset_mid();
    test_done_behaviour();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
